// File: rtl/mpe_pkg.sv
// Shared definitions for the MPE tile loader.
// Contents: loader state enum, activation type, default dimensions and counter widths, and
// the config sanitising function (0 -> 1, values above the maximum clamp to the maximum).
package mpe_pkg;

  localparam int unsigned DEF_BIN_LEN       = 8;
  localparam int unsigned DEF_INPUT_HEIGHT  = 8;
  localparam int unsigned DEF_INPUT_WIDTH   = 8;
  localparam int unsigned DEF_KERNEL_HEIGHT = 3;
  localparam int unsigned DEF_KERNEL_WIDTH  = 3;

  // Kernel counters carry one extra bit so kernel_h/kernel_w == maximum is representable.
  localparam int unsigned KH_CNT_W = $clog2(DEF_KERNEL_HEIGHT) + 1;
  localparam int unsigned KW_CNT_W = $clog2(DEF_KERNEL_WIDTH) + 1;
  localparam int unsigned ROW_CNT_W = $clog2(DEF_INPUT_HEIGHT);

  typedef enum logic {LOAD, SWEEP} loader_state_e;

  typedef logic [DEF_BIN_LEN-1:0] bin_t;

  function automatic int unsigned eff_cfg(input int unsigned cfg, input int unsigned max_val);
    if (cfg == 0) return 1;
    if (cfg > max_val) return max_val;
    return cfg;
  endfunction

endpackage

// File: rtl/mpe_kernel_pos_counter.sv
// Two-dimensional wrap counter that walks kernel offsets in row-major order.
// Ports: clock, reset (sync, active-high), clear (hold at origin), advance (step once),
//        kernel_h/kernel_w (effective extents), weight_height/weight_width (current offset),
//        first (at origin), last (at final offset).
module mpe_kernel_pos_counter
  import mpe_pkg::*;
#(
  parameter int unsigned CNT_H_W = KH_CNT_W,
  parameter int unsigned CNT_W_W = KW_CNT_W,
  parameter int unsigned OUT_H_W = KH_CNT_W - 1,
  parameter int unsigned OUT_W_W = KW_CNT_W - 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               advance,
  input  logic [CNT_H_W-1:0] kernel_h,
  input  logic [CNT_W_W-1:0] kernel_w,
  output logic [OUT_H_W-1:0] weight_height,
  output logic [OUT_W_W-1:0] weight_width,
  output logic               first,
  output logic               last
);

  logic [CNT_H_W-1:0] h_q;
  logic [CNT_W_W-1:0] w_q;
  logic               h_end;
  logic               w_end;

  assign h_end = (h_q == kernel_h - CNT_H_W'(1));
  assign w_end = (w_q == kernel_w - CNT_W_W'(1));

  assign first = (h_q == '0) && (w_q == '0);
  assign last  = h_end && w_end;

  assign weight_height = h_q[OUT_H_W-1:0];
  assign weight_width  = w_q[OUT_W_W-1:0];

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      h_q <= '0;
      w_q <= '0;
    end else if (advance) begin
      if (w_end) begin
        w_q <= '0;
        h_q <= h_end ? '0 : h_q + CNT_H_W'(1);
      end else begin
        w_q <= w_q + CNT_W_W'(1);
      end
    end
  end

endmodule

// File: rtl/mpe_tile_loader.sv
// Loads one input tile row by row, then sweeps every kernel offset over a valid/ready port.
// Ports: clock, reset (sync, active-high); cfg_kernel_h/cfg_kernel_w/cfg_stride (sampled on
//        the first row of each tile); row_valid/row_ready/row_data (row stream in);
//        in_vals (held tile); weight_height/weight_width/stride (current position);
//        pos_valid/pos_ready/pos_first/pos_last (position handshake); busy (sweeping).
// Optional: define MPE_TILE_LOADER_PERF_EN to add perf_tiles, perf_stall_cycles and
//        perf_starve_cycles saturating counters.
module mpe_tile_loader
  import mpe_pkg::*;
#(
  parameter int unsigned BIN_LEN       = DEF_BIN_LEN,
  parameter int unsigned INPUT_HEIGHT  = DEF_INPUT_HEIGHT,
  parameter int unsigned INPUT_WIDTH   = DEF_INPUT_WIDTH,
  parameter int unsigned KERNEL_HEIGHT = DEF_KERNEL_HEIGHT,
  parameter int unsigned KERNEL_WIDTH  = DEF_KERNEL_WIDTH
) (
  input  logic                                                clock,
  input  logic                                                reset,
  input  logic [$clog2(KERNEL_HEIGHT):0]                      cfg_kernel_h,
  input  logic [$clog2(KERNEL_WIDTH):0]                       cfg_kernel_w,
  input  logic [2:0]                                          cfg_stride,
  input  logic                                                row_valid,
  output logic                                                row_ready,
  input  logic [INPUT_WIDTH*BIN_LEN-1:0]                      row_data,
  output logic [INPUT_HEIGHT-1:0][INPUT_WIDTH-1:0][BIN_LEN-1:0] in_vals,
  output logic [$clog2(KERNEL_HEIGHT)-1:0]                    weight_height,
  output logic [$clog2(KERNEL_WIDTH)-1:0]                     weight_width,
  output logic [2:0]                                          stride,
  output logic                                                pos_valid,
  input  logic                                                pos_ready,
  output logic                                                pos_first,
  output logic                                                pos_last,
  output logic                                                busy
`ifdef MPE_TILE_LOADER_PERF_EN
  ,
  output logic [31:0]                                         perf_tiles,
  output logic [31:0]                                         perf_stall_cycles,
  output logic [31:0]                                         perf_starve_cycles
`endif
);

  localparam int unsigned KH_W  = $clog2(KERNEL_HEIGHT) + 1;
  localparam int unsigned KW_W  = $clog2(KERNEL_WIDTH) + 1;
  localparam int unsigned ROW_W = $clog2(INPUT_HEIGHT);

  loader_state_e    state;
  logic [ROW_W-1:0] row_cnt;
  logic [KH_W-1:0]  kernel_h;
  logic [KW_W-1:0]  kernel_w;
  logic             cnt_first;
  logic             cnt_last;
  logic             row_hs;
  logic             pos_hs;

  assign row_ready = (state == LOAD);
  assign busy      = (state == SWEEP);
  assign pos_valid = busy;
  // Counter sits at the origin during LOAD, so its flags must be masked there.
  assign pos_first = busy && cnt_first;
  assign pos_last  = busy && cnt_last;

  assign row_hs = row_valid && row_ready;
  assign pos_hs = pos_valid && pos_ready;

  mpe_kernel_pos_counter #(
    .CNT_H_W (KH_W),
    .CNT_W_W (KW_W),
    .OUT_H_W (KH_W - 1),
    .OUT_W_W (KW_W - 1)
  ) u_pos_counter (
    .clock         (clock),
    .reset         (reset),
    .clear         (state == LOAD),
    .advance       (pos_hs),
    .kernel_h      (kernel_h),
    .kernel_w      (kernel_w),
    .weight_height (weight_height),
    .weight_width  (weight_width),
    .first         (cnt_first),
    .last          (cnt_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= LOAD;
      row_cnt  <= '0;
      in_vals  <= '0;
      kernel_h <= KH_W'(1);
      kernel_w <= KW_W'(1);
      stride   <= 3'd1;
    end else begin
      unique case (state)
        LOAD: begin
          if (row_hs) begin
            in_vals[row_cnt] <= row_data;
            // Tile geometry is fixed by the first row only.
            if (row_cnt == '0) begin
              kernel_h <= KH_W'(eff_cfg(32'(cfg_kernel_h), KERNEL_HEIGHT));
              kernel_w <= KW_W'(eff_cfg(32'(cfg_kernel_w), KERNEL_WIDTH));
              stride   <= 3'(eff_cfg(32'(cfg_stride), 7));
            end
            if (row_cnt == ROW_W'(INPUT_HEIGHT - 1)) begin
              row_cnt <= '0;
              state   <= SWEEP;
            end else begin
              row_cnt <= row_cnt + ROW_W'(1);
            end
          end
        end
        SWEEP: begin
          if (pos_hs && cnt_last) state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

`ifdef MPE_TILE_LOADER_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_tiles         <= '0;
      perf_stall_cycles  <= '0;
      perf_starve_cycles <= '0;
    end else begin
      if (pos_hs && cnt_last && (perf_tiles != '1)) perf_tiles <= perf_tiles + 32'd1;
      if (pos_valid && !pos_ready && (perf_stall_cycles != '1)) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
      if ((state == LOAD) && !row_valid && (row_cnt != '0) && (perf_starve_cycles != '1)) begin
        perf_starve_cycles <= perf_starve_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mpe_tile_loader.sv
module tb_mpe_tile_loader;

  localparam int BL = 8;
  localparam int IH = 8;
  localparam int IW = 8;
  localparam int KH = 3;
  localparam int KW = 3;

  logic                           clock = 1'b0;
  logic                           reset;
  logic [2:0]                     cfg_kernel_h;
  logic [2:0]                     cfg_kernel_w;
  logic [2:0]                     cfg_stride;
  logic                           row_valid;
  logic                           row_ready;
  logic [IW*BL-1:0]               row_data;
  logic [IH-1:0][IW-1:0][BL-1:0]  in_vals;
  logic [1:0]                     weight_height;
  logic [1:0]                     weight_width;
  logic [2:0]                     stride;
  logic                           pos_valid;
  logic                           pos_ready;
  logic                           pos_first;
  logic                           pos_last;
  logic                           busy;
`ifdef MPE_TILE_LOADER_PERF_EN
  logic [31:0]                    perf_tiles;
  logic [31:0]                    perf_stall_cycles;
  logic [31:0]                    perf_starve_cycles;
`endif

  mpe_tile_loader u_dut (
    .clock         (clock),
    .reset         (reset),
    .cfg_kernel_h  (cfg_kernel_h),
    .cfg_kernel_w  (cfg_kernel_w),
    .cfg_stride    (cfg_stride),
    .row_valid     (row_valid),
    .row_ready     (row_ready),
    .row_data      (row_data),
    .in_vals       (in_vals),
    .weight_height (weight_height),
    .weight_width  (weight_width),
    .stride        (stride),
    .pos_valid     (pos_valid),
    .pos_ready     (pos_ready),
    .pos_first     (pos_first),
    .pos_last      (pos_last),
    .busy          (busy)
`ifdef MPE_TILE_LOADER_PERF_EN
    ,
    .perf_tiles         (perf_tiles),
    .perf_stall_cycles  (perf_stall_cycles),
    .perf_starve_cycles (perf_starve_cycles)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [IH-1:0][IW-1:0][BL-1:0] exp_tile;
  int exp_kh;
  int exp_kw;
  int exp_stride;
  int exp_tiles;
  int exp_stall;
  int exp_starve;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int eff(input int cfg, input int max_val);
    if (cfg == 0) return 1;
    if (cfg > max_val) return max_val;
    return cfg;
  endfunction

  task automatic check_perf();
`ifdef MPE_TILE_LOADER_PERF_EN
    check("perf_tiles", perf_tiles, exp_tiles);
    check("perf_stall", perf_stall_cycles, exp_stall);
    check("perf_starve", perf_starve_cycles, exp_starve);
`endif
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset     = 1'b1;
    row_valid = 1'b0;
    pos_ready = 1'b0;
    @(negedge clock);
    reset      = 1'b0;
    exp_tile   = '0;
    exp_stride = 1;
    exp_tiles  = 0;
    exp_stall  = 0;
    exp_starve = 0;
    check("rst_row_ready", row_ready, 1);
    check("rst_pos_valid", pos_valid, 0);
    check("rst_pos_first", pos_first, 0);
    check("rst_pos_last", pos_last, 0);
    check("rst_busy", busy, 0);
    check("rst_wh", weight_height, 0);
    check("rst_ww", weight_width, 0);
    check("rst_stride", stride, 1);
    check("rst_in_vals", in_vals, 0);
    check_perf();
  endtask

  // Presents n_rows rows; cfg is only meaningful on row 0, other rows carry junk cfg.
  task automatic load_tile(input int kh, input int kw, input int st, input bit pattern,
                           input bit gaps, input int n_rows);
    logic [IW*BL-1:0] data;
    for (int r = 0; r < n_rows; r++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clock);
          check("gap_row_ready", row_ready, 1);
          row_valid = 1'b0;
          if (r != 0) exp_starve++;
        end
      end
      @(negedge clock);
      check("load_row_ready", row_ready, 1);
      check("load_pos_valid", pos_valid, 0);
      check("load_busy", busy, 0);
      for (int c = 0; c < IW; c++) begin
        data[c*BL +: BL] = pattern ? 8'(r * 8 + c) : 8'($urandom);
      end
      row_valid = 1'b1;
      row_data  = data;
      if (r == 0) begin
        cfg_kernel_h = 3'(kh);
        cfg_kernel_w = 3'(kw);
        cfg_stride   = 3'(st);
        exp_kh       = eff(kh, KH);
        exp_kw       = eff(kw, KW);
        exp_stride   = eff(st, 7);
      end else begin
        cfg_kernel_h = 3'($urandom);
        cfg_kernel_w = 3'($urandom);
        cfg_stride   = 3'($urandom);
      end
      exp_tile[r] = data;
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: ready pattern 1,0,0,1 then 1.
  task automatic sweep(input int mode, input int stop_after);
    int eh[$];
    int ew[$];
    int n;
    int idx = 0;
    int k = 0;
    int budget = 0;
    bit rdy;
    for (int h = 0; h < exp_kh; h++) begin
      for (int w = 0; w < exp_kw; w++) begin
        eh.push_back(h);
        ew.push_back(w);
      end
    end
    n = eh.size();
    while (idx < n && idx != stop_after) begin
      @(negedge clock);
      if (budget++ > 300) begin
        check("sweep_timeout", 0, 1);
        break;
      end
      check("sw_pos_valid", pos_valid, 1);
      check("sw_busy", busy, 1);
      check("sw_row_ready", row_ready, 0);
      check("sw_wh", weight_height, eh[idx]);
      check("sw_ww", weight_width, ew[idx]);
      check("sw_first", pos_first, idx == 0);
      check("sw_last", pos_last, idx == n - 1);
      check("sw_stride", stride, exp_stride);
      check("sw_in_vals", in_vals, exp_tile);
      row_valid    = 1'($urandom_range(0, 1));
      row_data     = {$urandom, $urandom};
      cfg_kernel_h = 3'($urandom);
      cfg_kernel_w = 3'($urandom);
      cfg_stride   = 3'($urandom);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (k == 1 || k == 2) ? 1'b0 : 1'b1;
      endcase
      k++;
      pos_ready = rdy;
      if (rdy) begin
        idx++;
        if (idx == n) exp_tiles++;
      end else begin
        exp_stall++;
      end
    end
    if (idx == n) begin
      @(negedge clock);
      check("end_pos_valid", pos_valid, 0);
      check("end_row_ready", row_ready, 1);
      check("end_busy", busy, 0);
      check("end_in_vals", in_vals, exp_tile);
      row_valid = 1'b0;
      pos_ready = 1'b0;
    end
  endtask

  initial begin
    reset        = 1'b1;
    row_valid    = 1'b0;
    row_data     = '0;
    pos_ready    = 1'b0;
    cfg_kernel_h = '0;
    cfg_kernel_w = '0;
    cfg_stride   = '0;
    do_reset();

    // Counting pattern, 3x3, always ready.
    load_tile(3, 3, 1, 1'b1, 1'b0, IH);
    sweep(0, -1);
    check("in_vals_2_5", in_vals[2][5], 8'd21);
    check_perf();

    // 0 -> 1 and clamp rules.
    load_tile(0, 5, 0, 1'b0, 1'b1, IH);
    sweep(0, -1);
    check_perf();

    // Back-pressure pattern.
    load_tile(3, 2, 4, 1'b0, 1'b0, IH);
    sweep(2, -1);
    check_perf();

    // Randomized tiles.
    for (int t = 0; t < 8; t++) begin
      load_tile(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), 1'b0, 1'b1, IH);
      sweep(1, -1);
    end
    check_perf();

    // Reset mid-load, then a fresh tile.
    load_tile(2, 3, 2, 1'b0, 1'b0, 4);
    do_reset();
    load_tile(2, 3, 2, 1'b0, 1'b1, IH);
    sweep(1, -1);
    check_perf();

    // Reset mid-sweep, then a fresh tile.
    load_tile(3, 3, 1, 1'b0, 1'b0, IH);
    sweep(0, 2);
    do_reset();
    load_tile(1, 1, 3, 1'b0, 1'b0, IH);
    sweep(0, -1);
    load_tile(3, 3, 1, 1'b0, 1'b0, IH);
    sweep(1, -1);
    check_perf();

    // Two back-to-back 2x2 tiles.
    do_reset();
    load_tile(2, 2, 1, 1'b0, 1'b0, IH);
    sweep(1, -1);
    load_tile(2, 2, 1, 1'b0, 1'b0, IH);
    sweep(1, -1);
    check_perf();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
